// File: rtl/dcache_refill_engine.sv
// L1 data-cache miss refill engine: acknowledges a read or write miss, fetches the
// block from the next level as a multi-beat burst, and presents it as a full-mask fill.
//
//   state   | meaning
//   IDLE    | waiting for a miss request (read has priority)
//   ISSUE   | burst request held on the memory channel until accepted
//   FILL    | collecting response beats into the block buffer
//   RESOLVE | one-cycle fill presentation to the cache
module dcache_refill_engine #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 1024,
  parameter int MEM_DATA_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_repair_request,
  input  logic [ADDR_W-1:0]         missed_raddr,
  input  logic                      write_repair_request,
  input  logic [ADDR_W-1:0]         missed_waddr,
  output logic                      read_repair_req_acq,
  output logic                      write_repair_req_acq,
  output logic                      repair_resolved,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [BLOCK_BITS-1:0]     fill_data,
  output logic [BLOCK_BITS/8-1:0]   fill_mask,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_resp_valid,
  input  logic [MEM_DATA_W-1:0]     mem_resp_data
);

  localparam int BEATS = BLOCK_BITS / MEM_DATA_W;
  localparam int OFF   = $clog2(BLOCK_BITS / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FILL, RESOLVE} state_t;

  state_t                  state, state_nxt;
  logic                    accept_rd, accept_wr;
  logic                    issue_first;
  logic                    src_wr;
  logic [ADDR_W-1:0]       addr_q;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    beat_fire, beat_last;
  logic [BLOCK_BITS-1:0]   blk_buf, blk_nxt;

  assign beat_fire = (state == FILL) && mem_resp_valid;
  assign beat_last = beat_fire && (beat_cnt == LAST_BEAT);

  always_comb begin
    state_nxt = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    case (state)
      IDLE: begin
        if (read_repair_request) begin
          accept_rd = 1'b1;
          state_nxt = ISSUE;
        end else if (write_repair_request) begin
          accept_wr = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (mem_req_ready) state_nxt = FILL;
      FILL:    if (beat_last) state_nxt = RESOLVE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    blk_nxt = blk_buf;
    if (beat_fire) blk_nxt[beat_cnt*MEM_DATA_W +: MEM_DATA_W] = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_first <= 1'b0;
      src_wr      <= 1'b0;
      addr_q      <= '0;
      beat_cnt    <= '0;
      blk_buf     <= '0;
      fill_addr   <= '0;
      fill_data   <= '0;
    end else begin
      state       <= state_nxt;
      issue_first <= accept_rd | accept_wr;
      if (accept_rd | accept_wr) begin
        addr_q <= (accept_rd ? missed_raddr : missed_waddr) & ALIGN_MASK;
        src_wr <= accept_wr;
      end
      if (beat_fire) begin
        blk_buf  <= blk_nxt;
        beat_cnt <= beat_cnt + 1'b1;
      end
      // fill outputs are registered so they hold while the next burst overwrites the buffer
      if (beat_last) begin
        fill_data <= blk_nxt;
        fill_addr <= addr_q;
      end
    end
  end

  assign read_repair_req_acq  = issue_first & ~src_wr;
  assign write_repair_req_acq = issue_first & src_wr;
  assign mem_req_valid        = (state == ISSUE);
  assign mem_req_addr         = addr_q;
  assign repair_resolved      = (state == RESOLVE);
  assign fill_mask            = (state == RESOLVE) ? '1 : '0;

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Randomized bench for dcache_refill_engine: drives cache miss requests and a memory
// responder, and checks every fill against the block assembled from the beats sent.
module tb_dcache_refill_engine;

  localparam int ADDR_W     = 32;
  localparam int BLOCK_BITS = 1024;
  localparam int MEM_DATA_W = 128;
  localparam int BEATS      = BLOCK_BITS / MEM_DATA_W;
  localparam logic [31:0]  ALIGN = 32'hFFFF_FF80;
  localparam logic [127:0] ALL1  = '1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    read_repair_request = 1'b0;
  logic [ADDR_W-1:0]       missed_raddr = '0;
  logic                    write_repair_request = 1'b0;
  logic [ADDR_W-1:0]       missed_waddr = '0;
  logic                    read_repair_req_acq;
  logic                    write_repair_req_acq;
  logic                    repair_resolved;
  logic [ADDR_W-1:0]       fill_addr;
  logic [BLOCK_BITS-1:0]   fill_data;
  logic [BLOCK_BITS/8-1:0] fill_mask;
  logic                    mem_req_valid;
  logic                    mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic                    mem_resp_valid = 1'b0;
  logic [MEM_DATA_W-1:0]   mem_resp_data = '0;

  int total = 0, bad = 0;
  int n_rd_acq = 0, n_wr_acq = 0, n_res = 0;
  int exp_rd = 0, exp_wr = 0, exp_res = 0;

  always #5 clk = ~clk;

  dcache_refill_engine dut (
    .clk(clk), .rst(rst),
    .read_repair_request(read_repair_request), .missed_raddr(missed_raddr),
    .write_repair_request(write_repair_request), .missed_waddr(missed_waddr),
    .read_repair_req_acq(read_repair_req_acq), .write_repair_req_acq(write_repair_req_acq),
    .repair_resolved(repair_resolved), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_mask(fill_mask), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (read_repair_req_acq) n_rd_acq++;
      if (write_repair_req_acq) n_wr_acq++;
      if (repair_resolved) n_res++;
      check("acq_exclusive", read_repair_req_acq & write_repair_req_acq, 0);
      check("mask_vs_resolve", fill_mask, repair_resolved ? ALL1 : 128'd0);
    end
  end

  // Caller has raised the request line(s) in a cycle where the engine is IDLE.
  task automatic run_miss(input bit rd, input logic [31:0] addr, input int ready_lat,
                          input int gap_min, input int gap_max, input bit seq_data,
                          input bit raise_other, input logic [31:0] oaddr);
    logic [127:0] beats [BEATS];
    logic [31:0]  blk;
    int           gaps;
    bit           first;
    blk = addr & ALIGN;
    if (rd) exp_rd++; else exp_wr++;
    exp_res++;
    for (int j = 0; j <= ready_lat; j++) begin
      @(posedge clk); #1;
      mem_req_ready  = (j == ready_lat);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = rand128();
      @(negedge clk);
      check("rd_acq", read_repair_req_acq, (j == 0) && rd);
      check("wr_acq", write_repair_req_acq, (j == 0) && !rd);
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, blk);
    end
    first = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      gaps = $urandom_range(gap_min, gap_max);
      for (int g = 0; g <= gaps; g++) begin
        @(posedge clk); #1;
        if (first) begin
          if (rd) read_repair_request = 1'b0; else write_repair_request = 1'b0;
          first = 1'b0;
        end
        if (raise_other && k == 3 && g == 0) begin
          if (rd) begin write_repair_request = 1'b1; missed_waddr = oaddr; end
          else    begin read_repair_request  = 1'b1; missed_raddr = oaddr; end
        end
        mem_req_ready  = 1'($urandom_range(0, 1));
        mem_resp_valid = (g == gaps);
        mem_resp_data  = seq_data ? 128'(k) : rand128();
        if (g == gaps) beats[k] = mem_resp_data;
        @(negedge clk);
        check("fill_no_resolve", repair_resolved, 0);
        check("fill_no_acq", read_repair_req_acq | write_repair_req_acq, 0);
        check("fill_no_req", mem_req_valid, 0);
      end
    end
    @(posedge clk); #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data  = rand128();
    @(negedge clk);
    check("resolve", repair_resolved, 1);
    check("fill_addr", fill_addr, blk);
    check("fill_mask", fill_mask, ALL1);
    for (int k = 0; k < BEATS; k++) check($sformatf("fill_beat%0d", k), fill_data[k*MEM_DATA_W +: MEM_DATA_W], beats[k]);
    @(posedge clk); #1;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data  = rand128();
    @(negedge clk);
    check("resolve_one_cycle", repair_resolved, 0);
    check("post_no_acq", read_repair_req_acq | write_repair_req_acq, 0);
    check("post_req_idle", mem_req_valid, 0);
    check("hold_fill_addr", fill_addr, blk);
    check("hold_fill_beat0", fill_data[MEM_DATA_W-1:0], beats[0]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = rand128();
      @(negedge clk);
      check("idle_req", mem_req_valid, 0);
      check("idle_resolve", repair_resolved, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_acq"}, read_repair_req_acq, 0);
    check({tag, "_wr_acq"}, write_repair_req_acq, 0);
    check({tag, "_resolve"}, repair_resolved, 0);
    check({tag, "_fill_addr"}, fill_addr, 0);
    check({tag, "_fill_data"}, (fill_data == '0), 1);
    check({tag, "_fill_mask"}, fill_mask, 0);
    check({tag, "_req_valid"}, mem_req_valid, 0);
    check({tag, "_req_addr"}, mem_req_addr, 0);
  endtask

  initial begin
    logic [31:0] a;
    bit          rd;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // directed read miss with sequential beat data
    read_repair_request = 1'b1; missed_raddr = 32'h0000_1234;
    run_miss(1, 32'h0000_1234, 0, 0, 0, 1, 0, 0);

    // simultaneous read and write: read first, write pending
    @(posedge clk); #1;
    read_repair_request  = 1'b1; missed_raddr = 32'h0000_0100;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_2080;
    run_miss(1, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
    run_miss(0, 32'h0000_2080, 0, 0, 1, 0, 0, 0);

    // request-channel backpressure
    @(posedge clk); #1;
    read_repair_request = 1'b1; missed_raddr = 32'h0000_4044;
    run_miss(1, 32'h0000_4044, 5, 0, 0, 0, 0, 0);

    // spurious beats while idle, then alternating beats
    idle_cycles(4);
    @(posedge clk); #1;
    write_repair_request = 1'b1; missed_waddr = 32'hABCD_EF7F;
    run_miss(0, 32'hABCD_EF7F, 1, 1, 1, 0, 0, 0);

    // reset after beat 3 of 8
    @(posedge clk); #1;
    read_repair_request = 1'b1; missed_raddr = 32'h8000_0040; mem_req_ready = 1'b1;
    exp_rd++;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      read_repair_request = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = rand128();
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = rand128();
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rand128();
    @(negedge clk);
    check_all_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b1; mem_resp_data = rand128();
      @(negedge clk);
      check("aborted_beats_req", mem_req_valid, 0);
      check("aborted_beats_res", repair_resolved, 0);
    end
    @(posedge clk); #1;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_7000;
    run_miss(0, 32'h0000_7000, 0, 0, 0, 0, 0, 0);

    // request arrives during FILL and is held through resolve
    @(posedge clk); #1;
    read_repair_request = 1'b1; missed_raddr = 32'h0000_3000;
    run_miss(1, 32'h0000_3000, 0, 0, 1, 0, 1, 32'h0000_5555);
    run_miss(0, 32'h0000_5555, 0, 0, 0, 0, 0, 0);

    // random misses
    for (int i = 0; i < 25; i++) begin
      idle_cycles($urandom_range(0, 3));
      @(posedge clk); #1;
      rd = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (rd) begin read_repair_request = 1'b1; missed_raddr = a; missed_waddr = $urandom; end
      else    begin write_repair_request = 1'b1; missed_waddr = a; missed_raddr = $urandom; end
      run_miss(rd, a, $urandom_range(0, 3), 0, 2, 0, 0, 0);
    end

    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("count_rd_acq", n_rd_acq, exp_rd);
    check("count_wr_acq", n_wr_acq, exp_wr);
    check("count_resolve", n_res, exp_res);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_refill_engine.md
# dcache_refill_engine

Miss-service responder for the L1 data cache. It accepts read-miss and write-miss repair requests from the cache controller, acknowledges them, and fetches the missing 1024-bit block from the next memory level as a multi-beat burst. It assembles the block, then presents it as a full-mask fill with a one-cycle `repair_resolved` pulse. It sits inside the memory arbiter, between the cache-controller port and the L2/memory request channel.

## Interface
- `ADDR_W`, 32, byte-address width.
- `BLOCK_BITS`, 1024, cache block size (128 bytes).
- `MEM_DATA_W`, 128, memory response beat width. `BEATS = BLOCK_BITS/MEM_DATA_W` (8). `OFF = log2(BLOCK_BITS/8)` (7).

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `read_repair_request`  in  1  cache read miss pending; held until acknowledged.
- `missed_raddr`  in  ADDR_W  read-miss byte address.
- `write_repair_request`  in  1  cache write miss pending; held until acknowledged.
- `missed_waddr`  in  ADDR_W  write-miss byte address.
- `read_repair_req_acq`  out  1  one-cycle acknowledge of the read request.
- `write_repair_req_acq`  out  1  one-cycle acknowledge of the write request.
- `repair_resolved`  out  1  one-cycle pulse: the `fill_*` outputs are valid.
- `fill_addr`  out  ADDR_W  block-aligned fill address.
- `fill_data`  out  BLOCK_BITS  assembled block.
- `fill_mask`  out  BLOCK_BITS/8  byte write mask.
- `mem_req_valid`  out  1  burst read request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  ADDR_W  block-aligned burst address.
- `mem_resp_valid`  in  1  response beat valid.
- `mem_resp_data`  in  MEM_DATA_W  response beat.

## Operation
- FSM states and transitions:
  - IDLE: on any sampled request, go to ISSUE.
  - ISSUE: on `mem_req_valid & mem_req_ready`, go to FILL.
  - FILL: on the last beat, go to RESOLVE.
  - RESOLVE: go to IDLE after one cycle.
- Request acceptance:
  - Requests are sampled only in IDLE. They are ignored in every other state and in the cycle `repair_resolved` is high.
  - If both requests are high in the same IDLE cycle, read wins. The write request stays pending and is taken in a later IDLE cycle.
- On acceptance:
  - Latch `{addr[ADDR_W-1:OFF], OFF'b0}` from the selected address into an internal address register.
  - Latch a source flag (read/write).
- Acknowledge: the matching `*_req_acq` is high for exactly the first cycle in ISSUE, and never both at once.
- ISSUE: `mem_req_valid=1` and `mem_req_addr=` the latched address, held stable until the handshake.
- FILL:
  - Each `mem_resp_valid` beat k (counter 0..BEATS-1) is written to buffer bits `[k*MEM_DATA_W +: MEM_DATA_W]`.
  - The beat counter is `log2(BEATS)` bits wide. The beat at count BEATS-1 completes the fill and the counter wraps to 0.
  - Gaps between beats are allowed and unbounded.
- RESOLVE:
  - `repair_resolved=1`, `fill_addr=` latched address, `fill_data=` buffer, `fill_mask=` all ones.
  - In all other states `fill_mask=0` and `repair_resolved=0`.
  - `fill_addr` and `fill_data` hold their last values.
- `mem_resp_valid` outside FILL is ignored: no buffer update and no counter change.
- Reset (including mid-burst):
  - State returns to IDLE; counter, buffer, address register and all outputs clear to 0.
  - Beats still arriving for the aborted burst are ignored.

## Timing
- Reset values: every output is 0.
- Request sampled high in IDLE at edge N → ISSUE, acq and `mem_req_valid` high in cycle N+1.
- With `mem_req_ready` already high in N+1 → FILL from N+2.
- Last beat sampled at edge M → `repair_resolved` high in cycle M+1 only → IDLE at M+2.
- A pending request can be sampled at edge M+2; its acq appears in M+3.
- Minimum miss latency, from request to resolve: 3 + BEATS cycles (11 at defaults) with back-to-back beats.
- One miss is outstanding at a time; no request queueing beyond the cache's held request lines.

## Test plan
- Read miss: `missed_raddr=0x0000_1234` held high → one-cycle `read_repair_req_acq`, then `mem_req_addr=0x0000_1200`. Beats `0x0..0x7` → `repair_resolved` one cycle with `fill_data` beat k = k, `fill_addr=0x0000_1200`, `fill_mask` all ones.
- Simultaneous read (`0x100`) and write (`0x2080`) requests → read acked and resolved first. The write is then acked, with `mem_req_addr=0x2080`; exactly two resolve pulses and no double acks.
- Backpressure: `mem_req_ready` low for 5 cycles → `mem_req_valid` and `mem_req_addr` stay stable; no acq re-pulse; the fill completes normally afterwards.
- Gapped beats: `mem_resp_valid` toggles every other cycle, plus spurious beats while in IDLE → only the 8 in-FILL beats are captured, in order; resolve arrives one cycle after the 8th.
- Reset after beat 3 of 8 → all outputs 0 next cycle. The remaining 5 beats are ignored. A new request afterwards completes with fresh data and no stale beats.
- Request arriving during FILL, and held through resolve → not acked until IDLE; acq lands exactly 1 cycle after the IDLE sample.
